// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment bus decoder: active-low digit
// patterns, special nibble codes and the per-digit scan FSM states.
package seg7_pkg;

  // Segment order is {a,b,c,d,e,f,g}; a lit segment reads as 0.
  localparam logic [6:0] PAT_0     = 7'b0000001;
  localparam logic [6:0] PAT_1     = 7'b1001111;
  localparam logic [6:0] PAT_2     = 7'b0010010;
  localparam logic [6:0] PAT_3     = 7'b0000110;
  localparam logic [6:0] PAT_4     = 7'b1001100;
  localparam logic [6:0] PAT_5     = 7'b0100100;
  localparam logic [6:0] PAT_6     = 7'b0100000;
  localparam logic [6:0] PAT_7     = 7'b0001111;
  localparam logic [6:0] PAT_8     = 7'b0000000;
  localparam logic [6:0] PAT_9     = 7'b0000100;
  localparam logic [6:0] PAT_BLANK = 7'b1111111;

  localparam logic [3:0] BLANK   = 4'hF;
  localparam logic [3:0] ILLEGAL = 4'hE;

  typedef enum logic [1:0] {
    SCAN   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } scan_state_e;

  // Digit slot selected by a legal (one-bit-low) anode value.
  function automatic logic [1:0] an_slot(input logic [3:0] an);
    logic [1:0] slot;
    slot = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!an[i]) slot = 2'(i);
    end
    return slot;
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational decode of one active-low segment pattern into a BCD nibble,
// with blank mapped to BLANK and anything unrecognised flagged as illegal.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       illegal
);

  always_comb begin
    nibble  = ILLEGAL;
    illegal = 1'b0;
    case (seg)
      PAT_0:     nibble = 4'd0;
      PAT_1:     nibble = 4'd1;
      PAT_2:     nibble = 4'd2;
      PAT_3:     nibble = 4'd3;
      PAT_4:     nibble = 4'd4;
      PAT_5:     nibble = 4'd5;
      PAT_6:     nibble = 4'd6;
      PAT_7:     nibble = 4'd7;
      PAT_8:     nibble = 4'd8;
      PAT_9:     nibble = 4'd9;
      PAT_BLANK: nibble = BLANK;
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers a confirmed four-digit BCD value from a multiplexed active-low
// seven-segment bus by settling on each anode, sampling, and voting frames.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 16,
  parameter int FRAMES_MATCH   = 2,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic        clk_100MHz,
  input  logic        reset,
  input  logic [3:0]  an,
  input  logic [6:0]  seg,
  input  logic        dp,
  output logic [15:0] digits,
  output logic [3:0]  dp_mask,
  output logic        valid,
  output logic        update,
  output logic        err
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int MW = $clog2(FRAMES_MATCH + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [MW-1:0] MATCH_MAX   = MW'(FRAMES_MATCH);
  localparam logic [TW-1:0] TO_LAST     = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TO_MAX      = TW'(TIMEOUT_CYCLES);

  logic [3:0] an_meta_q, an_sync_q;
  logic [6:0] seg_meta_q, seg_sync_q;
  logic       dp_meta_q, dp_sync_q;

  scan_state_e     state_q, state_d;
  logic [3:0]      cur_an_q, cur_an_d;
  logic [SW-1:0]   settle_cnt_q, settle_cnt_d;
  logic [3:0]      seen_q, seen_d;
  logic [3:0][3:0] slot_nib_q, slot_nib_d;
  logic [3:0]      slot_dp_q, slot_dp_d;
  logic [3:0][3:0] cand_nib_q, cand_nib_d;
  logic [3:0]      cand_dp_q, cand_dp_d;
  logic [MW-1:0]   match_q, match_d;
  logic [TW-1:0]   to_cnt_q, to_cnt_d;
  logic [15:0]     digits_q, digits_d;
  logic [3:0]      dp_mask_q, dp_mask_d;
  logic            valid_q, valid_d;
  logic            update_q, update_d;
  logic            err_q, err_d;

  logic [3:0] dec_nib;
  logic       dec_illegal;

  seg7_pattern_decode u_decode (
    .seg     (seg_sync_q),
    .nibble  (dec_nib),
    .illegal (dec_illegal)
  );

  // Idle-high reset values keep the bus looking quiet until real data arrives.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      an_meta_q  <= 4'b1111;
      an_sync_q  <= 4'b1111;
      seg_meta_q <= PAT_BLANK;
      seg_sync_q <= PAT_BLANK;
      dp_meta_q  <= 1'b1;
      dp_sync_q  <= 1'b1;
    end else begin
      an_meta_q  <= an;
      an_sync_q  <= an_meta_q;
      seg_meta_q <= seg;
      seg_sync_q <= seg_meta_q;
      dp_meta_q  <= dp;
      dp_sync_q  <= dp_meta_q;
    end
  end

  logic            an_idle, an_legal, an_bad, enter, sample, complete, same, timeout_fire;
  logic [1:0]      slot;
  logic [3:0]      seen_next;
  logic [3:0][3:0] frame_nib;
  logic [3:0]      frame_dp;

  always_comb begin
    state_d      = state_q;
    cur_an_d     = cur_an_q;
    settle_cnt_d = settle_cnt_q;
    seen_d       = seen_q;
    slot_nib_d   = slot_nib_q;
    slot_dp_d    = slot_dp_q;
    cand_nib_d   = cand_nib_q;
    cand_dp_d    = cand_dp_q;
    match_d      = match_q;
    to_cnt_d     = to_cnt_q;
    digits_d     = digits_q;
    dp_mask_d    = dp_mask_q;
    valid_d      = valid_q;
    update_d     = 1'b0;
    err_d        = err_q;
    enter        = 1'b0;
    sample       = 1'b0;
    complete     = 1'b0;
    same         = 1'b0;

    an_idle  = (an_sync_q == 4'b1111);
    an_legal = (an_sync_q == 4'b1110) || (an_sync_q == 4'b1101) ||
               (an_sync_q == 4'b1011) || (an_sync_q == 4'b0111);
    an_bad   = !an_idle && !an_legal;

    // An anode change in SETTLE or HOLD is treated as a fresh SCAN in the same
    // cycle, so back-to-back digits each get their full settle window.
    if (an_bad) begin
      err_d        = 1'b1;
      seen_d       = 4'b0000;
      state_d      = SCAN;
      settle_cnt_d = '0;
    end else begin
      case (state_q)
        SCAN:   enter = 1'b1;
        SETTLE: begin
          if (an_sync_q != cur_an_q) begin
            enter = 1'b1;
          end else begin
            settle_cnt_d = settle_cnt_q + 1'b1;
            if (settle_cnt_q == SETTLE_LAST) begin
              sample  = 1'b1;
              state_d = HOLD;
            end
          end
        end
        HOLD:    enter = (an_sync_q != cur_an_q);
        default: enter = 1'b1;
      endcase
      if (enter) begin
        if (an_legal) begin
          state_d      = SETTLE;
          cur_an_d     = an_sync_q;
          settle_cnt_d = SW'(1);
        end else begin
          state_d      = SCAN;
          settle_cnt_d = '0;
        end
      end
    end

    slot      = an_slot(cur_an_q);
    frame_nib = slot_nib_q;
    frame_dp  = slot_dp_q;
    seen_next = seen_q;
    if (sample) begin
      frame_nib[slot] = dec_nib;
      frame_dp[slot]  = !dp_sync_q;
      seen_next[slot] = 1'b1;
      slot_nib_d      = frame_nib;
      slot_dp_d       = frame_dp;
      seen_d          = seen_next;
      if (dec_illegal) err_d = 1'b1;
    end

    complete = sample && (seen_next == 4'b1111);
    if (complete) begin
      same       = (frame_nib == cand_nib_q) && (frame_dp == cand_dp_q);
      cand_nib_d = frame_nib;
      cand_dp_d  = frame_dp;
      seen_d     = 4'b0000;
      if (!same)                   match_d = MW'(1);
      else if (match_q != MATCH_MAX) match_d = match_q + 1'b1;
      if (match_d == MATCH_MAX) begin
        digits_d  = frame_nib;
        dp_mask_d = frame_dp;
        valid_d   = 1'b1;
        update_d  = !valid_q || (frame_nib != digits_q) || (frame_dp != dp_mask_q);
      end
    end

    // A frame completing on the expiry cycle is discarded: timeout has priority.
    timeout_fire = (to_cnt_q == TO_LAST);
    if (sample)                to_cnt_d = '0;
    else if (to_cnt_q != TO_MAX) to_cnt_d = to_cnt_q + 1'b1;
    if (timeout_fire) begin
      valid_d    = 1'b0;
      match_d    = '0;
      seen_d     = 4'b0000;
      update_d   = 1'b0;
      digits_d   = digits_q;
      dp_mask_d  = dp_mask_q;
      cand_nib_d = cand_nib_q;
      cand_dp_d  = cand_dp_q;
    end
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state_q      <= SCAN;
      cur_an_q     <= 4'b1111;
      settle_cnt_q <= '0;
      seen_q       <= 4'b0000;
      slot_nib_q   <= '0;
      slot_dp_q    <= 4'b0000;
      cand_nib_q   <= '0;
      cand_dp_q    <= 4'b0000;
      match_q      <= '0;
      to_cnt_q     <= '0;
      digits_q     <= 16'hFFFF;
      dp_mask_q    <= 4'b0000;
      valid_q      <= 1'b0;
      update_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_an_q     <= cur_an_d;
      settle_cnt_q <= settle_cnt_d;
      seen_q       <= seen_d;
      slot_nib_q   <= slot_nib_d;
      slot_dp_q    <= slot_dp_d;
      cand_nib_q   <= cand_nib_d;
      cand_dp_q    <= cand_dp_d;
      match_q      <= match_d;
      to_cnt_q     <= to_cnt_d;
      digits_q     <= digits_d;
      dp_mask_q    <= dp_mask_d;
      valid_q      <= valid_d;
      update_q     <= update_d;
      err_q        <= err_d;
    end
  end

  assign digits  = digits_q;
  assign dp_mask = dp_mask_q;
  assign valid   = valid_q;
  assign update  = update_q;
  assign err     = err_q;

endmodule
